// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store unit - one data-memory transaction at a time, load
//           alignment/extension and register-file writeback.
// Latency : accept -> mem_req next cycle; load writeback one cycle after mem_rvalid.
// Backpr. : req_ready is high only in IDLE; mem_req is held with stable fields until
//           mem_gnt. A stalled bus aborts with a timeout error after WAIT_MAX cycles.
// Ports   : req_*  execute-stage request (valid/ready handshake)
//           mem_*  data-memory request/grant/response bus
//           wb_*   register-file write port (loads only, never for rd=0)
//           err/err_code  one-cycle error pulse (01 misaligned, 10 illegal, 11 timeout)
module load_store_unit #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_value,
  output logic        err,
  output logic [1:0]  err_code
);

  // The counter only has to reach WAIT_MAX-1: the cycle it sits there with no
  // progress is the WAIT_MAX-th stalled cycle.
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        op_load;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;
  logic [CW-1:0] cnt;

  logic        accept;
  logic        f3_ok;
  logic        misal;
  logic        tout;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] lane;
  logic [31:0] ld_val;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign tout      = (cnt == CNT_LAST);

  // Request decode: legality, alignment and store lane formatting.
  always_comb begin
    f3_ok    = 1'b0;
    misal    = 1'b0;
    st_strb  = 4'b1111;
    st_wdata = req_wdata;
    if (req_load)
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    else
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    // funct3[1:0] encodes access size for every legal opcode.
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load alignment: bring the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    lane = mem_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'b0, lane[7:0]};
      3'b101:  ld_val = {16'b0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && f3_ok && !misal) state_nxt = REQ;
      REQ: begin
        if (mem_gnt)   state_nxt = op_load ? WAIT : IDLE;
        else if (tout) state_nxt = IDLE;
      end
      WAIT: if (mem_rvalid || tout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_load   <= 1'b0;
      op_f3     <= 3'b000;
      op_off    <= 2'b00;
      op_rd     <= 5'd0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'd0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_value  <= 32'd0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      err   <= 1'b0;
      wb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_load <= req_load;
            op_f3   <= req_funct3;
            op_off  <= req_addr[1:0];
            op_rd   <= req_rd;
            cnt     <= '0;
            // Illegal funct3 is reported in preference to misalignment.
            if (!f3_ok) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end else if (misal) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= !req_load;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_load ? 4'b0000 : st_strb;
              mem_wdata <= st_wdata;
            end
          end
        end
        REQ: begin
          if (mem_gnt || tout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            cnt       <= '0;
            if (!mem_gnt) begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_value <= ld_val;
            wb_rd    <= op_rd;
            wb_we    <= (op_rd != 5'd0);
          end else if (tout) begin
            err      <= 1'b1;
            err_code <= 2'b11;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : self-checking bench for load_store_unit with a scoreboard of expected
//           bus requests, writebacks and error pulses.
// Latency : stimulus drives #1 after posedge; monitors sample on negedge.
// Backpr. : the bench's memory model grants/answers after programmable delays.
module tb_load_store_unit;

  localparam int TWM = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic        err;
  logic [1:0]  err_code;

  load_store_unit #(.WAIT_MAX(TWM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_value(wb_value), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  bus_t       bus_q[$];
  wb_t        wb_q[$];
  logic [1:0] err_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         wb_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Monitors: every bus cycle, writeback and error pulse must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        chk("bus_unexpected", 32'(bus_q.size() == 0), 0);
        if (bus_q.size() > 0) begin
          chk("mem_addr", mem_addr, bus_q[0].addr);
          chk("mem_we", mem_we, bus_q[0].we);
          chk("mem_wstrb", mem_wstrb, bus_q[0].strb);
          if (bus_q[0].we) chk("mem_wdata", mem_wdata, bus_q[0].wd);
          if (mem_gnt) bus_q.delete(0);
        end
      end else begin
        chk("we_idle", mem_we, 0);
        chk("wstrb_idle", mem_wstrb, 0);
      end
      if (wb_we) begin
        wb_seen++;
        chk("wb_unexpected", 32'(wb_q.size() == 0), 0);
        if (wb_q.size() > 0) begin
          chk("wb_rd", wb_rd, wb_q[0].rd);
          chk("wb_value", wb_value, wb_q[0].val);
          wb_q.delete(0);
        end
      end
      if (err) begin
        chk("err_unexpected", 32'(err_q.size() == 0), 0);
        if (err_q.size() > 0) begin
          chk("err_code", err_code, err_q[0]);
          err_q.delete(0);
        end
      end
    end
  end

  // Present one request for a single cycle; caller is positioned just after a posedge.
  task automatic present(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rv,
                       input logic [31:0] rdata, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wd, input logic [31:0] exp_val,
                       input logic [1:0] exp_err);
    bus_t b;
    wb_t  w;
    if (exp_err != 2'b00) begin
      err_q.push_back(exp_err);
      present(ld, f3, addr, wd, rd);
      chk("ready_after_err", req_ready, 1);
      @(posedge clk); #1;
      return;
    end
    b.addr = {addr[31:2], 2'b00}; b.we = !ld; b.strb = exp_strb; b.wd = exp_wd;
    bus_q.push_back(b);
    present(ld, f3, addr, wd, rd);
    repeat (gd) begin @(posedge clk); #1; end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (!ld) begin
      chk("ready_after_store", req_ready, 1);
      return;
    end
    repeat (rv) begin @(posedge clk); #1; end
    if (rd != 5'd0) begin
      w.rd = rd; w.val = exp_val;
      wb_q.push_back(w);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'hCAFE_F00D;
    chk("ready_after_load", req_ready, 1);
  endtask

  initial begin
    bus_t b;
    int   n;
    logic seen;

    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_value", wb_value, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ld  f3      addr          wdata         rd  gd rv rdata         strb     wdata exp     wb value      err
    do_op(0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        2'b00);
    do_op(0, 3'b000, 32'h103, 32'h000000A5, 5'd0, 0, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        2'b00);
    do_op(0, 3'b001, 32'h102, 32'h00001234, 5'd0, 1, 0, 32'h0,        4'b1100, 32'h12341234, 32'h0,        2'b00);
    do_op(1, 3'b000, 32'h201, 32'h0,        5'd5, 0, 0, 32'h00008000, 4'b0000, 32'h0,        32'hFFFFFF80, 2'b00);
    do_op(1, 3'b100, 32'h201, 32'h0,        5'd6, 0, 0, 32'h00008000, 4'b0000, 32'h0,        32'h00000080, 2'b00);
    do_op(1, 3'b101, 32'h202, 32'h0,        5'd7, 0, 0, 32'hBEEF0000, 4'b0000, 32'h0,        32'h0000BEEF, 2'b00);
    do_op(1, 3'b010, 32'h202, 32'h0,        5'd8, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01);
    do_op(1, 3'b011, 32'h200, 32'h0,        5'd8, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b10);
    do_op(0, 3'b100, 32'h200, 32'h0,        5'd0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b10);
    do_op(0, 3'b001, 32'h101, 32'h0,        5'd0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01);
    do_op(0, 3'b011, 32'h003, 32'h0,        5'd0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b10);
    do_op(1, 3'b010, 32'h300, 32'h0,        5'd0, 0, 0, 32'h55555555, 4'b0000, 32'h0,        32'h0,        2'b00);
    do_op(1, 3'b001, 32'h206, 32'h0,        5'd9, 3, 5, 32'h80010000, 4'b0000, 32'h0,        32'hFFFF8001, 2'b00);
    do_op(1, 3'b010, 32'h400, 32'h0,        5'd10,0, 0, 32'h12345678, 4'b0000, 32'h0,        32'h12345678, 2'b00);

    // Stray response while idle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;

    // Grant never comes: timeout after TWM cycles of mem_req.
    b.addr = 32'h600; b.we = 1'b1; b.strb = 4'b1111; b.wd = 32'h11112222;
    bus_q.push_back(b);
    err_q.push_back(2'b11);
    present(0, 3'b010, 32'h600, 32'h11112222, 5'd0);
    n = 0; seen = 1'b0;
    for (int i = 0; i < TWM + 10; i++) begin
      @(negedge clk);
      if (err) begin seen = 1'b1; break; end
      if (mem_req) n++;
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_req_cycles", n, TWM);
    chk("timeout_req_low", mem_req, 0);
    chk("timeout_ready", req_ready, 1);
    if (bus_q.size() > 0) bus_q.delete(0);
    @(posedge clk); #1;

    // Reset while waiting for read data: everything returns to reset values.
    b.addr = 32'h500; b.we = 1'b0; b.strb = 4'b0000; b.wd = 32'h0;
    bus_q.push_back(b);
    present(1, 3'b010, 32'h500, 32'h0, 5'd3);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_mem_req", mem_req, 0);
    chk("arst_wb_we", wb_we, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_wb_value", wb_value, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_err_code", err_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    chk("bus_q_drained", bus_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    chk("wb_pulse_count", wb_seen, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
